// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: counter encodings,
// BTB entry layout and the resolve bundle from the branch unit.
package branch_predictor_pkg;

  localparam int unsigned BP_ADDR_WIDTH = 32;
  localparam int unsigned BP_CNT_WIDTH  = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef struct packed {
    logic                     valid;
    logic [BP_ADDR_WIDTH-1:0] tag;
    logic [BP_ADDR_WIDTH-1:0] target;
    logic                     is_jump;
    logic [1:0]               ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [BP_ADDR_WIDTH-1:0] pc;
    logic                     taken;
    logic [BP_ADDR_WIDTH-1:0] target;
    logic                     is_jump;
    logic                     mispredict;
  } resolve_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter next-state function.
module branch_predictor_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next_c
);

  always_comb begin
    ctr_next_c = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next_c = 2'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_SNT) ctr_next_c = 2'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency fetch lookup, one-stage
// training pipeline from branch resolutions, and the mispredict redirect.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BP_ADDR_WIDTH,
  parameter int unsigned ENTRIES    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  resolve_valid,
  input  logic [ADDR_WIDTH-1:0] resolve_pc,
  input  logic                  resolve_taken,
  input  logic [ADDR_WIDTH-1:0] resolve_target,
  input  logic                  resolve_is_jump,
  input  logic                  resolve_mispredict,
  input  logic                  flush,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           mispredict_count
);

  localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_SHIFT  = INDEX_BITS + 2;

  btb_entry_t btb_q [ENTRIES];
  btb_entry_t btb_d [ENTRIES];

  resolve_t                  u1_q, u1_d;
  logic                      u1_valid_q, u1_valid_d;
  logic [BP_ADDR_WIDTH-1:0]  redirect_hold_q, redirect_hold_d;
  logic [BP_CNT_WIDTH-1:0]   count_q, count_d;

  logic [INDEX_BITS-1:0]     fetch_idx_c;
  logic [BP_ADDR_WIDTH-1:0]  fetch_tag_c;
  logic                      fetch_hit_c;
  logic [INDEX_BITS-1:0]     upd_idx_c;
  logic [BP_ADDR_WIDTH-1:0]  upd_tag_c;
  logic                      upd_hit_c;
  logic [1:0]                upd_ctr_c;
  logic [BP_ADDR_WIDTH-1:0]  u1_redir_pc_c;

  // Fetch lookup reads the table as of the last edge; no write bypass.
  always_comb begin
    fetch_idx_c    = fetch_pc[INDEX_BITS+1:2];
    fetch_tag_c    = BP_ADDR_WIDTH'(fetch_pc >> TAG_SHIFT);
    fetch_hit_c    = fetch_valid & btb_q[fetch_idx_c].valid &
                     (btb_q[fetch_idx_c].tag == fetch_tag_c);
    predict_taken  = fetch_hit_c &
                     (btb_q[fetch_idx_c].is_jump | btb_q[fetch_idx_c].ctr[1]);
    predict_target = '0;
    if (predict_taken) begin
      predict_target = ADDR_WIDTH'(btb_q[fetch_idx_c].target);
    end else if (fetch_valid) begin
      predict_target = fetch_pc + ADDR_WIDTH'(4);
    end
  end

  // Stage U1 capture and the count, both taken at the resolve edge.
  always_comb begin
    u1_valid_d        = resolve_valid & ~flush;
    u1_d.pc           = BP_ADDR_WIDTH'(resolve_pc);
    u1_d.taken        = resolve_taken;
    u1_d.target       = BP_ADDR_WIDTH'(resolve_target);
    u1_d.is_jump      = resolve_is_jump;
    u1_d.mispredict   = resolve_mispredict;
    count_d           = count_q + BP_CNT_WIDTH'(resolve_valid & ~flush & resolve_mispredict);
  end

  // Redirect is driven from the U1 register; the hold keeps the last target.
  always_comb begin
    u1_redir_pc_c   = u1_q.taken ? u1_q.target : u1_q.pc + BP_ADDR_WIDTH'(4);
    redirect_valid  = u1_valid_q & u1_q.mispredict;
    redirect_hold_d = redirect_valid ? u1_redir_pc_c : redirect_hold_q;
    redirect_pc     = ADDR_WIDTH'(redirect_hold_d);
  end

  assign mispredict_count = count_q;

  always_comb begin
    upd_idx_c = u1_q.pc[INDEX_BITS+1:2];
    upd_tag_c = BP_ADDR_WIDTH'(u1_q.pc >> TAG_SHIFT);
    upd_hit_c = btb_q[upd_idx_c].valid & (btb_q[upd_idx_c].tag == upd_tag_c);
  end

  branch_predictor_sat_counter2 u_sat_counter2 (
    .ctr        (btb_q[upd_idx_c].ctr),
    .taken      (u1_q.taken),
    .ctr_next_c (upd_ctr_c)
  );

  // Table write from U1: train on hit, allocate on a taken miss.
  always_comb begin
    btb_d = btb_q;
    if (u1_valid_q) begin
      if (upd_hit_c) begin
        btb_d[upd_idx_c].ctr = upd_ctr_c;
        if (u1_q.taken) begin
          btb_d[upd_idx_c].target  = u1_q.target;
          btb_d[upd_idx_c].is_jump = u1_q.is_jump;
        end
      end else if (u1_q.taken) begin
        btb_d[upd_idx_c] = '{valid: 1'b1, tag: upd_tag_c, target: u1_q.target,
                             is_jump: u1_q.is_jump, ctr: CTR_WT};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u1_valid_q      <= 1'b0;
      u1_q            <= '0;
      redirect_hold_q <= '0;
      count_q         <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0, ctr: CTR_WNT};
      end
    end else begin
      u1_valid_q      <= u1_valid_d;
      u1_q            <= u1_d;
      redirect_hold_q <= redirect_hold_d;
      count_q         <= count_d;
      btb_q           <= btb_d;
    end
  end

endmodule
